// File: rtl/conv_pkg.sv
// Shared widths, FSM state encodings and index-width helper for the convolution stream controller.
package conv_pkg;

  localparam int PIX_W = 9;
  localparam int WT_W  = 8;
  localparam int ACC_W = 24;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Line buffers (K_H-1 rows of IMG_W pixels) feeding a K_HxK_W window shift register.
// Everything advances only on shift_en; the newest pixel lands in window column K_W-1 of the bottom row.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int K_H   = 3,
  parameter int K_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en,
  input  logic [PIX_W-1:0]           pix_in,
  output logic [K_H*K_W*PIX_W-1:0]   win_out
);

  logic [PIX_W-1:0] rows [K_H-1][IMG_W];
  logic [PIX_W-1:0] taps [K_H];
  logic [PIX_W-1:0] win  [K_H][K_W];

  // Row r of the window is fed from the pixel seen (K_H-1-r) lines ago.
  always_comb begin
    for (int r = 0; r < K_H; r++) begin
      taps[r] = '0;
    end
    taps[K_H-1] = pix_in;
    for (int r = 0; r < K_H-1; r++) begin
      taps[r] = rows[K_H-2-r][IMG_W-1];
    end
  end

  // Row FIFOs and the window shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < K_H-1; j++) begin
        for (int i = 0; i < IMG_W; i++) begin
          rows[j][i] <= '0;
        end
      end
      for (int r = 0; r < K_H; r++) begin
        for (int c = 0; c < K_W; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (shift_en) begin
      rows[0][0] <= pix_in;
      for (int j = 1; j < K_H-1; j++) begin
        rows[j][0] <= rows[j-1][IMG_W-1];
      end
      for (int j = 0; j < K_H-1; j++) begin
        for (int i = 1; i < IMG_W; i++) begin
          rows[j][i] <= rows[j][i-1];
        end
      end
      for (int r = 0; r < K_H; r++) begin
        for (int c = 0; c < K_W-1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K_W-1] <= taps[r];
      end
    end
  end

  // Flatten the window, element (r,c) at slot r*K_W+c.
  always_comb begin
    win_out = '0;
    for (int r = 0; r < K_H; r++) begin
      for (int c = 0; c < K_W; c++) begin
        win_out[(r*K_W+c)*PIX_W +: PIX_W] = win[r][c];
      end
    end
  end

endmodule

// File: rtl/conv_stream_ctrl.sv
// Convolution stream controller: FSM, pixel counters, weight file and registered output slot.
// Optional macro CONV_STATS_EN adds the stat_outs / stat_stall counters.
module conv_stream_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_H  = 8,
  parameter int IMG_W  = 8,
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int NUM_PE = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  input  logic                               wt_we,
  input  logic [idx_w(NUM_PE*K_H*K_W)-1:0]   wt_addr,
  input  logic [WT_W-1:0]                    wt_data,
  input  logic                               pix_valid,
  output logic                               pix_ready,
  input  logic [PIX_W-1:0]                   pix_data,
  output logic [K_H*K_W*PIX_W-1:0]           pe_win,
  output logic [NUM_PE*K_H*K_W*WT_W-1:0]     pe_w,
  input  logic [NUM_PE*ACC_W-1:0]            pe_result,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_PE*ACC_W-1:0]            out_data,
  output logic [idx_w(IMG_H)-1:0]            out_row,
  output logic [idx_w(IMG_W)-1:0]            out_col
`ifdef CONV_STATS_EN
  ,
  output logic [15:0]                        stat_outs,
  output logic [15:0]                        stat_stall
`endif
);

  localparam int NW = NUM_PE*K_H*K_W;
  localparam int RW = idx_w(IMG_H);
  localparam int CW = idx_w(IMG_W);

  state_t          state;
  state_t          state_nxt;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic            win_vld;
  logic [RW-1:0]   tag_row;
  logic [CW-1:0]   tag_col;
  logic [WT_W-1:0] wt [NW];

  logic            start_ok;
  logic            accept;
  logic            last_pix;
  logic            win_done;
  logic            slot_load;

  conv_line_buf #(
    .IMG_W (IMG_W),
    .K_H   (K_H),
    .K_W   (K_W)
  ) u_line_buf (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .pix_in   (pix_data),
    .win_out  (pe_win)
  );

  // Handshake and window-completion decode.
  always_comb begin
    start_ok  = (state == ST_IDLE) && start;
    pix_ready = (state == ST_RUN) && (!win_vld || !out_valid || out_ready);
    accept    = pix_valid && pix_ready;
    last_pix  = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
    win_done  = accept && (row >= RW'(K_H-1)) && (col >= CW'(K_W-1));
    slot_load = win_vld && (!out_valid || out_ready);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
        else       state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (accept && last_pix) state_nxt = ST_FLUSH;
        else                    state_nxt = ST_RUN;
      end
      ST_FLUSH: begin
        if (!win_vld && !out_valid) state_nxt = ST_DONE;
        else                        state_nxt = ST_FLUSH;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with busy/done decoded from the next state so they are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN) || (state_nxt == ST_FLUSH);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_W-1)) begin
        col <= '0;
        row <= last_pix ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Pending-window flag and its output coordinates.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      win_vld <= 1'b0;
      tag_row <= '0;
      tag_col <= '0;
    end else if (win_done) begin
      win_vld <= 1'b1;
      tag_row <= row - RW'(K_H-1);
      tag_col <= col - CW'(K_W-1);
    end else if (slot_load) begin
      win_vld <= 1'b0;
    end
  end

  // Output slot: captures the lanes' results for the pending window, holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (slot_load) begin
      out_valid <= 1'b1;
      out_data  <= pe_result;
      out_row   <= tag_row;
      out_col   <= tag_col;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Weight register file, writable only between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) begin
        wt[k] <= '0;
      end
    end else if ((state == ST_IDLE) && wt_we && (int'(wt_addr) < NW)) begin
      wt[wt_addr] <= wt_data;
    end
  end

  // Weight image, lane p occupying slots p*K_H*K_W .. p*K_H*K_W+K_H*K_W-1.
  always_comb begin
    pe_w = '0;
    for (int k = 0; k < NW; k++) begin
      pe_w[k*WT_W +: WT_W] = wt[k];
    end
  end

`ifdef CONV_STATS_EN
  // Per-frame saturating counters of output handshakes and input stalls.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stat_outs  <= 16'h0000;
      stat_stall <= 16'h0000;
    end else begin
      if (out_valid && out_ready && (stat_outs != 16'hFFFF)) begin
        stat_outs <= stat_outs + 16'h0001;
      end
      if (((state == ST_RUN) || (state == ST_FLUSH)) && pix_valid && !pix_ready &&
          (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Scoreboard bench for conv_stream_ctrl on a 5x5 frame with a behavioural ReLU lane model.
module tb_conv_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, busy, done;
  logic         wt_we;
  logic [5:0]   wt_addr;
  logic [7:0]   wt_data;
  logic         pix_valid, pix_ready;
  logic [8:0]   pix_data;
  logic [80:0]  pe_win;
  logic [287:0] pe_w;
  logic [95:0]  pe_result;
  logic         out_valid, out_ready;
  logic [95:0]  out_data;
  logic [2:0]   out_row, out_col;
`ifdef CONV_STATS_EN
  logic [15:0]  stat_outs, stat_stall;
`endif

  typedef struct {
    logic [95:0] data;
    int          row;
    int          col;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_hs, n_done, stall_cnt;
  bit   aborted;

  always #5 clk = ~clk;

  conv_stream_ctrl #(.IMG_H(5), .IMG_W(5), .K_H(3), .K_W(3), .NUM_PE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pe_win(pe_win), .pe_w(pe_w), .pe_result(pe_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
`ifdef CONV_STATS_EN
    , .stat_outs(stat_outs), .stat_stall(stat_stall)
`endif
  );

  // Lane model: signed dot product of window and lane weights, then ReLU.
  always_comb begin
    int acc, pv, wv;
    pe_result = '0;
    for (int p = 0; p < 4; p++) begin
      acc = 0;
      for (int k = 0; k < 9; k++) begin
        pv  = int'($signed(pe_win[k*9 +: 9]));
        wv  = int'($signed(pe_w[p*72 + k*8 +: 8]));
        acc = acc + pv * wv;
      end
      pe_result[p*24 +: 24] = (acc < 0) ? 24'd0 : acc[23:0];
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Test 0: all +1, 1: all -1, 2: lane p weight p+1, 3: one-hot tap per lane.
  function automatic logic [7:0] wt_of(input int test, input int p, input int k);
    case (test)
      0: return 8'd1;
      1: return 8'hFF;
      2: return 8'(p + 1);
      default: begin
        case (p)
          0: return (k == 0) ? 8'd1 : 8'd0;
          1: return (k == 8) ? 8'd1 : 8'd0;
          2: return (k == 2) ? 8'd1 : 8'd0;
          default: return (k == 6) ? 8'd1 : 8'd0;
        endcase
      end
    endcase
  endfunction

  function automatic logic [287:0] w_image(input int test);
    logic [287:0] img;
    for (int k = 0; k < 36; k++) img[k*8 +: 8] = wt_of(test, k / 9, k % 9);
    return img;
  endfunction

  // Pixel (r,c) = 5r+c+1, so the all-ones window sum at (i,j) is 63+45i+9j.
  function automatic int exp_lane(input int test, input int p, input int i, input int j);
    int base;
    base = 63 + 45*i + 9*j;
    case (test)
      0: return base;
      1: return 0;
      2: return (p + 1) * base;
      default: begin
        case (p)
          0: return 5*i + j + 1;
          1: return 5*(i+2) + (j+2) + 1;
          2: return 5*i + (j+2) + 1;
          default: return 5*(i+2) + j + 1;
        endcase
      end
    endcase
  endfunction

  function automatic logic [95:0] exp_data(input int test, input int i, input int j);
    logic [95:0] d;
    int v;
    for (int p = 0; p < 4; p++) begin
      v = exp_lane(test, p, i, j);
      d[p*24 +: 24] = v[23:0];
    end
    return d;
  endfunction

  // Monitor: pops the scoreboard on every output handshake; also counts done pulses and stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) n_done++;
      if (busy && pix_valid && !pix_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        n_hs++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got output (%0d,%0d) with empty queue", out_row, out_col);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_row", out_row, 3'(e.row));
          chk("out_col", out_col, 3'(e.col));
        end
      end
    end
  end

  task automatic load_w(input int test);
    for (int k = 0; k < 36; k++) begin
      wt_we   = 1'b1;
      wt_addr = 6'(k);
      wt_data = wt_of(test, k / 9, k % 9);
      @(posedge clk); #1;
    end
    wt_we = 1'b0;
  endtask

  task automatic run_frame(input int test, input int rst_at, input bit stall, input bit inject);
    int n;
    n_hs      = 0;
    n_done    = 0;
    stall_cnt = 0;
    aborted   = 1'b0;
    out_ready = !stall;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_run", busy, 1'b1);
    @(posedge clk); #1;
    fork
      begin
        for (int idx = 0; idx < 25; idx++) begin
          if (inject && idx == 5) begin
            wt_we = 1'b1; wt_addr = 6'd0; wt_data = 8'h7F; start = 1'b1;
          end
          if (idx == rst_at) begin
            pix_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            q.delete();
            @(negedge clk);
            chk("rst_busy", busy, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            @(posedge clk); #1;
            aborted = 1'b1;
            break;
          end
          if (idx % 7 == 3) begin
            pix_valid = 1'b0;
            @(posedge clk); #1;
          end
          pix_valid = 1'b1;
          pix_data  = 9'(idx + 1);
          n = 0;
          @(negedge clk);
          while (!pix_ready && n < 100) begin
            n++;
            @(negedge clk);
          end
          if (n >= 100) begin
            chk("pix_timeout", pix_ready, 1'b1);
            aborted = 1'b1;
            break;
          end
          @(posedge clk);
          if (idx / 5 >= 2 && idx % 5 >= 2)
            q.push_back('{exp_data(test, idx/5 - 2, idx%5 - 2), idx/5 - 2, idx%5 - 2});
          #1;
          wt_we = 1'b0;
          start = 1'b0;
        end
        pix_valid = 1'b0;
      end
      begin
        if (stall) begin
          n = 0;
          @(negedge clk);
          while (!out_valid && n < 200) begin
            n++;
            @(negedge clk);
          end
          for (int s = 0; s < 10; s++) begin
            chk("stall_hold", {out_valid, out_row, out_col, out_data},
                {1'b1, 3'd0, 3'd0, exp_data(test, 0, 0)});
            if (s == 9) chk("stall_pix_ready", pix_ready, 1'b0);
            @(negedge clk);
          end
          @(posedge clk); #1 out_ready = 1'b1;
        end
      end
    join
    if (!aborted) begin
      n = 0;
      @(negedge clk);
      while (!done && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("done_seen", done, 1'b1);
    end
    repeat (3) @(negedge clk);
    chk("done_count", n_done, aborted ? 0 : 1);
    if (!aborted) chk("out_count", n_hs, 9);
    chk("queue_empty", q.size(), 0);
    chk("busy_idle", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy0", busy, 1'b0);
    chk("rst_done0", done, 1'b0);
    chk("rst_pix_ready0", pix_ready, 1'b0);
    chk("rst_out_valid0", out_valid, 1'b0);
    chk("rst_out_data0", out_data, 96'd0);
    chk("rst_out_row0", out_row, 3'd0);
    chk("rst_out_col0", out_col, 3'd0);
    chk("rst_pe_w0", pe_w, 288'd0);
    @(posedge clk); #1;

    load_w(0);
    chk("pe_w_ones", pe_w, w_image(0));
    run_frame(0, -1, 1'b0, 1'b0);

    load_w(1);
    run_frame(1, -1, 1'b0, 1'b0);

    load_w(2);
    run_frame(2, -1, 1'b1, 1'b0);
`ifdef CONV_STATS_EN
    chk("stat_outs", stat_outs, 16'd9);
    chk("stat_stall", stat_stall, 16'(stall_cnt));
`endif

    load_w(3);
    run_frame(3, -1, 1'b0, 1'b1);
    chk("pe_w_after_inject", pe_w, w_image(3));

    load_w(0);
    run_frame(0, 13, 1'b0, 1'b0);
    chk("pe_w_after_rst", pe_w, 288'd0);
    load_w(0);
    run_frame(0, -1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
